// File: rtl/argmax_pkg.sv
// Shared definitions for the softmax argmax stage: sizes, FSM states and
// IEEE-754 single-precision constants used by the compare logic.
package argmax_pkg;

    localparam int unsigned N_CLASS = 7;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]        EXP_MAX  = 8'hFF;
    localparam logic [DATA_W-1:0] POS_ZERO = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NEG_ZERO = 32'h8000_0000;

endpackage

// File: rtl/softmax_argmax_fp32_gt.sv
// Strict float32 greater-than (a > b) with a monotonic integer key,
// signed-zero equality and NaN-never-wins ordering.
module fp32_gt
    import argmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    logic              a_nan;
    logic              b_nan;
    logic              both_zero;
    logic [DATA_W-1:0] a_key;
    logic [DATA_W-1:0] b_key;

    assign a_nan = (a[DATA_W-2 -: 8] == EXP_MAX) && (a[22:0] != '0);
    assign b_nan = (b[DATA_W-2 -: 8] == EXP_MAX) && (b[22:0] != '0);

    // +0.0 and -0.0 map to adjacent keys, so equality must be forced explicitly.
    assign both_zero = ((a | NEG_ZERO) == NEG_ZERO) && ((b | NEG_ZERO) == NEG_ZERO);

    assign a_key = a[DATA_W-1] ? ~a : (a | NEG_ZERO);
    assign b_key = b[DATA_W-1] ? ~b : (b | NEG_ZERO);

    always_comb begin
        gt = 1'b0;
        if (!a_nan) begin
            gt = b_nan || (!both_zero && (a_key > b_key));
        end
    end

endmodule

// File: rtl/softmax_argmax.sv
// Final classification stage: captures seven float32 probabilities and
// scans them with one shared comparator to report the argmax and its value.
module softmax_argmax
    import argmax_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] class0,
    input  logic [DATA_W-1:0] class1,
    input  logic [DATA_W-1:0] class2,
    input  logic [DATA_W-1:0] class3,
    input  logic [DATA_W-1:0] class4,
    input  logic [DATA_W-1:0] class5,
    input  logic [DATA_W-1:0] class6,
    output logic              valid_out,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_val,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last;
    logic              cand_gt;
    logic [DATA_W-1:0] in_vec [N_CLASS];
    logic [DATA_W-1:0] cap    [N_CLASS];
    logic [DATA_W-1:0] best;
    logic [IDX_W-1:0]  best_idx;
    logic [IDX_W-1:0]  cnt;

    assign in_vec = '{class0, class1, class2, class3, class4, class5, class6};
    assign busy   = (state == SCAN);

    fp32_gt u_gt (
        .a  (cap[cnt]),
        .b  (best),
        .gt (cand_gt)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (cnt == IDX_W'(N_CLASS - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                accept    = valid_in;
                state_nxt = valid_in ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_CLASS; i++) cap[i] <= POS_ZERO;
            best      <= POS_ZERO;
            best_idx  <= '0;
            cnt       <= '0;
            valid_out <= 1'b0;
            class_idx <= '0;
            max_val   <= POS_ZERO;
        end else begin
            valid_out <= last;
            if (accept) begin
                for (int unsigned i = 0; i < N_CLASS; i++) cap[i] <= in_vec[i];
                best     <= class0;
                best_idx <= '0;
                cnt      <= IDX_W'(1);
            end else if (state == SCAN) begin
                if (cand_gt) begin
                    best     <= cap[cnt];
                    best_idx <= cnt;
                end
                cnt <= cnt + IDX_W'(1);
            end
            // The final compare result is folded straight into the outputs so
            // the result is registered on the same edge as the last compare.
            if (last) begin
                class_idx <= cand_gt ? cnt : best_idx;
                max_val   <= cand_gt ? cap[cnt] : best;
            end
        end
    end

endmodule

// File: tb/tb_softmax_argmax.sv
// Self-checking bench for softmax_argmax: directed corner vectors plus
// randomized vectors against a numeric-ordering reference model.
module tb_softmax_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] vin [7];
    logic        valid_out;
    logic [2:0]  class_idx;
    logic [31:0] max_val;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    softmax_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .class0    (vin[0]),
        .class1    (vin[1]),
        .class2    (vin[2]),
        .class3    (vin[3]),
        .class4    (vin[4]),
        .class5    (vin[5]),
        .class6    (vin[6]),
        .valid_out (valid_out),
        .class_idx (class_idx),
        .max_val   (max_val),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Numeric a > b for non-NaN floats, reasoned in sign/magnitude terms.
    function automatic logic num_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic int ref_idx();
        int best = 0;
        for (int i = 1; i < 7; i++)
            if (!is_nan(vin[i]) && (is_nan(vin[best]) || num_gt(vin[i], vin[best])))
                best = i;
        return best;
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0: return r;
            1: return {r[31], 8'hFF, 23'd0};
            2: return {r[31], 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
            3: return {r[31], 31'd0};
            4: return {r[31], 8'h00, r[22:0]};
            default: return {1'b0, 8'($urandom_range(100, 126)), r[22:0]};
        endcase
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_out && n < 20);
    endtask

    task automatic run_vec(input string tag);
        int          n;
        int          e_idx;
        logic [31:0] e_val;
        e_idx = ref_idx();
        e_val = vin[e_idx];
        @(negedge clk); valid_in = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        wait_valid(n);
        check({tag, ".lat"}, n, 6);
        check({tag, ".idx"}, 32'(class_idx), 32'(e_idx));
        check({tag, ".val"}, max_val, e_val);
        @(negedge clk);
        check({tag, ".pulse"}, 32'(valid_out), 32'd0);
        check({tag, ".hold"}, 32'(class_idx), 32'(e_idx));
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 7; i++) vin[i] = v;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int n2;

        // Reset with valid_in high must not capture anything.
        rst = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 7; i++) vin[i] = $urandom;
        @(negedge clk); @(negedge clk);
        check("rst.valid", 32'(valid_out), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.idx", 32'(class_idx), 32'd0);
        check("rst.val", max_val, 32'h0);
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst.nocap", 32'(busy), 32'd0);

        set_all(32'h3E00_0000); vin[4] = 32'h3F00_0000;
        run_vec("basic");

        set_all(32'h3D00_0000); vin[2] = 32'h3F00_0000; vin[5] = 32'h3F00_0000;
        run_vec("tie");

        set_all(32'hC000_0000);
        vin[0] = 32'h7FC0_0000; vin[1] = 32'hBF80_0000;
        vin[3] = 32'h8000_0000; vin[6] = 32'h0000_0000;
        run_vec("signs");

        for (int i = 0; i < 7; i++) vin[i] = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 1000))};
        run_vec("allnan");

        set_all(32'hFF80_0000); vin[5] = 32'h0000_0001;
        run_vec("denorm");

        // Pulse during SCAN is ignored; valid_in in DONE is taken back-to-back.
        set_all(32'h3E00_0000); vin[1] = 32'h3F40_0000;
        @(negedge clk); valid_in = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk); @(negedge clk);
        set_all(32'h4000_0000);
        valid_in = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        wait_valid(n);
        check("hs.lat", n, 3);
        check("hs.idx", 32'(class_idx), 32'd1);
        check("hs.val", max_val, 32'h3F40_0000);
        set_all(32'h0); vin[6] = 32'h3F80_0000;
        valid_in = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        wait_valid(n2);
        check("b2b.gap", n2 + 1, 7);
        check("b2b.idx", 32'(class_idx), 32'd6);
        check("b2b.val", max_val, 32'h3F80_0000);
        @(negedge clk);

        // Reset sampled on E3 aborts the scan.
        set_all(32'h3E00_0000); vin[3] = 32'h3F00_0000;
        @(negedge clk); valid_in = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort.valid", 32'(valid_out), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.idx", 32'(class_idx), 32'd0);
        check("abort.val", max_val, 32'h0);
        wait_valid(n);
        check("abort.noout", n, 20);
        run_vec("after_abort");

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 7; i++) begin
                if (i > 0 && $urandom_range(0, 4) == 0) vin[i] = vin[$urandom_range(0, i - 1)];
                else vin[i] = rand_elem();
            end
            run_vec($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
